// File: rtl/fb_pkg.sv
// Shared definitions for the framebuffer painter: geometry, swap FSM encoding
// and the 4-bit to 8-bit gamma table.
package fb_pkg;

  localparam int FB_COLS      = 64;
  localparam int FB_ROWS_HALF = 32;
  localparam int COLOR_BITS   = 12;
  localparam int FB_ADDR_W    = 12;  // {buffer, row[4:0], col[5:0]}

  typedef enum logic {
    SWAP_IDLE    = 1'b0,
    SWAP_PENDING = 1'b1
  } swap_state_t;

  // Entry n occupies bits [8n+7:8n].
  localparam logic [16*8-1:0] GAMMA_TABLE = {
    8'd255, 8'd219, 8'd186, 8'd156, 8'd129, 8'd105, 8'd83, 8'd64,
    8'd48,  8'd34,  8'd23,  8'd14,  8'd7,   8'd3,   8'd1,  8'd0
  };

endpackage

// File: rtl/fb_ram.sv
// Simple dual-port RAM, one write port and one registered read port on the
// same clock; shaped for block-RAM inference. Contents are never reset.
module fb_ram
  import fb_pkg::*;
#(
  parameter int DATA_W = COLOR_BITS,
  parameter int ADDR_W = FB_ADDR_W
) (
  input  logic              clk,
  input  logic              i_we,
  input  logic [ADDR_W-1:0] i_waddr,
  input  logic [DATA_W-1:0] i_wdata,
  input  logic [ADDR_W-1:0] i_raddr,
  output logic [DATA_W-1:0] o_rdata
);

  logic [DATA_W-1:0] r_mem [0:(1<<ADDR_W)-1];
  logic [DATA_W-1:0] r_rdata_p1;

  always_ff @(posedge clk) begin
    if (i_we) begin
      r_mem[i_waddr] <= i_wdata;
    end
  end

  // p0 -> p1: registered read
  always_ff @(posedge clk) begin
    r_rdata_p1 <= r_mem[i_raddr];
  end

  assign o_rdata = r_rdata_p1;

endmodule

// File: rtl/fb_painter.sv
// Double-buffered 4:4:4 framebuffer for one panel half with gamma-corrected
// PWM output and tear-free buffer swap on frame boundaries.
module fb_painter
  import fb_pkg::*;
#(
  parameter logic HALF = 1'b0
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [12:0] frame,
  input  logic [7:0]  subframe,
  input  logic [5:0]  x,
  input  logic [5:0]  y,
  output logic [2:0]  rgb,
  input  logic        wr_valid,
  output logic        wr_ready,
  input  logic [5:0]  wr_x,
  input  logic [5:0]  wr_y,
  input  logic [11:0] wr_color,
  input  logic        swap_req,
  output logic        swap_pending,
  output logic        swap_done
);

  swap_state_t r_state, w_state_nxt;
  logic        w_toggle;
  logic        r_front;
  logic        r_swap_done;
  logic [12:0] r_last_frame;
  logic [7:0]  r_subframe_p1;
  logic        r_vld_p1;

  logic                  w_frame_edge;
  logic                  w_wr_accept;
  logic                  w_we;
  logic [FB_ADDR_W-1:0]  w_waddr;
  logic [FB_ADDR_W-1:0]  w_raddr;
  logic [COLOR_BITS-1:0] w_pix_p1;
  logic                  w_unused;

  function automatic logic gamma_lit(input logic [3:0] lvl, input logic [7:0] thr);
    logic [7:0] g;
    g = GAMMA_TABLE[{lvl, 3'b000} +: 8];
    return g > thr;
  endfunction

  // The driver only asks for rows of this half, so the row MSB is not decoded.
  assign w_unused = y[5];

  assign w_frame_edge = (frame != r_last_frame);
  assign swap_pending = (r_state == SWAP_PENDING);
  assign swap_done    = r_swap_done;
  assign wr_ready     = ~swap_pending & ~reset;

  // Beats for the other half are still handshaken so both halves stay in lockstep.
  assign w_wr_accept = wr_valid & wr_ready;
  assign w_we        = w_wr_accept & (wr_y[5] == HALF);
  assign w_waddr     = {~r_front, wr_y[4:0], wr_x};
  assign w_raddr     = {r_front, y[4:0], x};

  always_comb begin
    w_state_nxt = r_state;
    w_toggle    = 1'b0;
    case (r_state)
      SWAP_IDLE: begin
        if (swap_req) begin
          w_state_nxt = SWAP_PENDING;
        end
      end
      SWAP_PENDING: begin
        if (w_frame_edge) begin
          w_state_nxt = SWAP_IDLE;
          w_toggle    = 1'b1;
        end
      end
      default: w_state_nxt = SWAP_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state       <= SWAP_IDLE;
      r_front       <= 1'b0;
      r_swap_done   <= 1'b0;
      r_last_frame  <= frame;
      r_subframe_p1 <= 8'hFF;
      r_vld_p1      <= 1'b0;
    end else begin
      r_state       <= w_state_nxt;
      r_swap_done   <= w_toggle;
      r_last_frame  <= frame;
      r_subframe_p1 <= subframe;
      r_vld_p1      <= 1'b1;
      if (w_toggle) begin
        r_front <= ~r_front;
      end
    end
  end

  fb_ram #(
    .DATA_W(COLOR_BITS),
    .ADDR_W(FB_ADDR_W)
  ) u_ram (
    .clk    (clk),
    .i_we   (w_we),
    .i_waddr(w_waddr),
    .i_wdata(wr_color),
    .i_raddr(w_raddr),
    .o_rdata(w_pix_p1)
  );

  // p1: gamma compare against the threshold captured with the read address
  always_comb begin
    rgb = 3'b000;
    if (r_vld_p1) begin
      rgb = {gamma_lit(w_pix_p1[11:8], r_subframe_p1),
             gamma_lit(w_pix_p1[7:4],  r_subframe_p1),
             gamma_lit(w_pix_p1[3:0],  r_subframe_p1)};
    end
  end

endmodule
